// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// A grant lasts one burst, ended by req_last or after MAXBURST accepted beats.
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_last,
    input  logic [NREQ*DATASIZE-1:0]   req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DATASIZE-1:0]        wdata,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          r_state,    w_state_nxt;
    logic [GW-1:0]   r_grant_id, w_grant_nxt;
    logic [GW-1:0]   r_rr_ptr,   w_rr_nxt;
    logic [CW-1:0]   r_beat_cnt, w_cnt_nxt;

    logic            w_accept;
    logic            w_found;
    logic [GW-1:0]   w_winner;

    // Circular priority scan starting at r_rr_ptr; first valid requester wins.
    always_comb begin
        logic [GW:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(NREQ))
                idx = idx - (GW+1)'(NREQ);
            if (!w_found && req_valid[idx[GW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[GW-1:0];
            end
        end
    end

    assign w_accept = (r_state == S_BURST) && req_valid[r_grant_id] && !wfull;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_cnt_nxt   = r_beat_cnt;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BURST;
                    w_grant_nxt = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            S_BURST: begin
                if (w_accept) begin
                    w_cnt_nxt = r_beat_cnt + 1'b1;
                    // Release on last or once the MAXBURST-th beat goes out.
                    if (req_last[r_grant_id] || (r_beat_cnt == CW'(MAXBURST - 1))) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_rr_nxt    = (r_grant_id == GW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Outputs decode from registered state so reset kills winc without a clock.
    for (genvar i = 0; i < NREQ; i++) begin : g_ready
        assign req_ready[i] = w_accept && (r_grant_id == GW'(i));
    end

    assign winc     = w_accept;
    assign wdata    = req_data[int'(r_grant_id)*DATASIZE +: DATASIZE];
    assign grant_id = r_grant_id;
    assign busy     = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter: per-requester beat queues feed the
// drivers and a scoreboard; a negedge monitor checks arbitration and data.
module tb_fifo_wr_arbiter;

    localparam int DATASIZE = 8;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 8;

    logic                       wclk;
    logic                       wrst_n;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_last;
    logic [NREQ*DATASIZE-1:0]   req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       wfull;
    logic                       winc;
    logic [DATASIZE-1:0]        wdata;
    logic [$clog2(NREQ)-1:0]    grant_id;
    logic                       busy;

    fifo_wr_arbiter #(.DATASIZE(DATASIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .busy(busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [DATASIZE-1:0] data;
        logic                last;
    } beat_t;

    beat_t drv_q[NREQ][$];
    beat_t exp_q[NREQ][$];
    int    pop_cnt[NREQ];
    int    gate_pct;
    int    full_pct;
    int    n_chk;
    int    n_fail;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += drv_q[i].size();
        return s;
    endfunction

    task automatic push_beat(input int r, input logic [DATASIZE-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        drv_q[r].push_back(b);
        exp_q[r].push_back(b);
    endtask

    task automatic push_burst(input int r, input int len);
        for (int b = 0; b < len; b++)
            push_beat(r, DATASIZE'($urandom), b == len - 1);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (drv_q[i].size() > 0) begin
                req_valid[i] = ($urandom_range(99) < gate_pct);
                req_data[i*DATASIZE +: DATASIZE] = drv_q[i][0].data;
                req_last[i] = drv_q[i][0].last;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        wfull = ($urandom_range(99) < full_pct);
    endtask

    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge wclk);
        acc = req_ready & req_valid;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (acc[i]) begin
                void'(drv_q[i].pop_front());
                pop_cnt[i]++;
            end
        drive();
    endtask

    task automatic drain(input int budget);
        int n = budget;
        while (pending() > 0 && n > 0) begin
            cycle();
            n--;
        end
        chk("drain_pending", pending(), 0);
        repeat (3) cycle();
    endtask

    // Reference view: grants follow round-robin from the last holder + 1, a
    // burst ends after last or MAXBURST beats, and one idle cycle separates grants.
    int              m_rr, m_cnt, prev_gid;
    logic            prev_rst, prev_busy, prev_winc, prev_last;
    logic [NREQ-1:0] prev_valid;

    initial begin
        int              g;
        logic [NREQ-1:0] er;
        beat_t           b;
        prev_rst = 1'b1;
        m_rr = 0;
        m_cnt = 0;
        forever begin
            @(negedge wclk);
            if (!wrst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_winc", winc, 0);
                chk("rst_grant", grant_id, 0);
                chk("rst_ready", req_ready, 0);
                m_rr = 0;
                m_cnt = 0;
                prev_rst = 1'b1;
            end else begin
                if (!prev_rst) begin
                    if (prev_busy) begin
                        if (prev_winc && (prev_last || m_cnt == MAXBURST)) begin
                            chk("release_gap", busy, 0);
                            m_rr = (prev_gid + 1) % NREQ;
                            m_cnt = 0;
                        end else begin
                            chk("hold_busy", busy, 1);
                            chk("hold_grant", grant_id, prev_gid);
                        end
                    end else if (prev_valid != '0) begin
                        chk("grant_busy", busy, 1);
                        chk("grant_id", grant_id, rr_pick(m_rr, prev_valid));
                        m_cnt = 0;
                    end else begin
                        chk("idle_busy", busy, 0);
                    end
                end
                g  = int'(grant_id);
                er = '0;
                if (busy && req_valid[g] && !wfull) er[g] = 1'b1;
                chk("ready", req_ready, er);
                chk("winc", winc, int'(|er));
                prev_last = 1'b0;
                if (busy && winc) begin
                    if (exp_q[g].size() == 0) begin
                        chk("sb_underflow", exp_q[g].size(), 1);
                    end else begin
                        b = exp_q[g].pop_front();
                        chk("wdata", wdata, b.data);
                        prev_last = b.last;
                    end
                    m_cnt++;
                end
                prev_busy  = busy;
                prev_winc  = winc;
                prev_gid   = g;
                prev_valid = req_valid;
                prev_rst   = 1'b0;
            end
        end
    end

    initial begin
        int start;
        int n;
        n_chk = 0;
        n_fail = 0;
        gate_pct = 100;
        full_pct = 0;
        for (int i = 0; i < NREQ; i++) pop_cnt[i] = 0;
        wrst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        wfull = 1'b0;

        // Single requester 2, three beats.
        push_beat(2, 8'hA1, 1'b0);
        push_beat(2, 8'hA2, 1'b0);
        push_beat(2, 8'hA3, 1'b1);
        repeat (3) @(posedge wclk);
        #1;
        drive();
        wrst_n = 1'b1;
        drain(200);
        chk("t1_busy_after", busy, 0);

        // Everyone continuously valid with single-beat bursts.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_burst(i, 1);
        drive();
        drain(200);

        // wfull held for three cycles after beat 2 of a 5-beat burst.
        push_burst(1, 5);
        drive();
        start = pop_cnt[1];
        n = 100;
        while (pop_cnt[1] < start + 2 && n > 0) begin cycle(); n--; end
        full_pct = 100;
        drive();
        repeat (2) cycle();
        chk("t3_no_winc_full", winc, 0);
        full_pct = 0;
        drain(200);
        chk("t3_total_beats", pop_cnt[1] - start, 5);

        // 12-beat stream forces a MAXBURST release.
        push_burst(0, 12);
        drive();
        drain(200);

        // Asynchronous reset during beat 3.
        push_burst(1, 6);
        drive();
        start = pop_cnt[1];
        n = 100;
        while (pop_cnt[1] < start + 2 && n > 0) begin cycle(); n--; end
        push_burst(3, 2);
        drive();
        chk("t5_pre_rst_winc", winc, 1);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("t5_async_winc", winc, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_grant", grant_id, 0);
        cycle();
        wrst_n = 1'b1;
        drain(300);
        chk("t5_req1_beats", pop_cnt[1] - start, 6);

        // Random traffic with bubbles and backpressure.
        gate_pct = 70;
        full_pct = 20;
        for (int k = 0; k < 60; k++)
            push_burst($urandom_range(NREQ - 1), $urandom_range(12, 1));
        drive();
        drain(20000);

        n = 0;
        for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
        chk("sb_leftover", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
